// File: rtl/axis_spi_master_core.sv
// ---------------------------------------------------------------------------
// axis_spi_master_core
//   SPI master driven by AXI-Stream. Each accepted s_axis word is shifted out
//   MSB first on MOSI while MISO is shifted in; the received word is presented
//   on m_axis when the chip select rises. A new word is only accepted once the
//   previous received word has been taken, so no data is ever dropped.
//
// Parameters
//   SPI_MODE   : 0..3, CPOL = bit 1, CPHA = bit 0
//   DATA_WIDTH : bits per SPI word and AXI-Stream tdata width
//   MAIN_CLK   : clk_i frequency in Hz
//   SPI_CLK    : SCLK frequency in Hz
//   SLAVE_NUM  : number of chip selects
//   WAIT_TIME  : clk_i cycles of CS-high idle between words
//
// Ports
//   clk_i, arstn_i      : clock, asynchronous active-low reset
//   addr_i              : slave index, sampled when a word is accepted
//   spi_clk_o           : SCLK, idles at CPOL
//   spi_cs_o            : active-low chip selects
//   spi_mosi_o          : serial data out
//   spi_miso_i          : serial data in
//   s_axis_t*           : words to transmit
//   m_axis_t*           : received words
//
// Optional build macro
//   AXIS_SPI_ASSERT_EN  : compiles parameter sanity checks and an m_axis
//                         hold-stability assertion (simulation only).
// ---------------------------------------------------------------------------
module axis_spi_master_core #(
    parameter int SPI_MODE   = 0,
    parameter int DATA_WIDTH = 8,
    parameter int MAIN_CLK   = 27_000_000,
    parameter int SPI_CLK    = 6_750_000,
    parameter int SLAVE_NUM  = 1,
    parameter int WAIT_TIME  = 50,
    localparam int AW        = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [AW-1:0]         addr_i,
    output logic                  spi_clk_o,
    output logic [SLAVE_NUM-1:0]  spi_cs_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam bit CPOL   = ((SPI_MODE / 2) % 2) == 1;
    localparam bit CPHA   = (SPI_MODE % 2) == 1;
    localparam int HP_RAW = MAIN_CLK / (2 * SPI_CLK);
    localparam int HP     = (HP_RAW < 1) ? 1 : HP_RAW;
    localparam int HW     = (HP > 1) ? $clog2(HP) : 1;
    localparam int EW     = $clog2(2 * DATA_WIDTH + 1);
    localparam int WW     = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;

    typedef enum logic [1:0] {IDLE, TRANSFER, WAIT} state_t;

    state_t                r_state;
    logic [HW-1:0]         r_hcnt;
    logic [EW-1:0]         r_edge;
    logic [WW-1:0]         r_wcnt;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_sclk;
    logic [SLAVE_NUM-1:0]  r_cs;
    logic                  r_mosi;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_s_tready;

    logic                  w_hp_done;
    logic                  w_edges_done;
    logic                  w_leading;
    logic                  w_sample;
    logic                  w_m_hold;
    logic [DATA_WIDTH-1:0] w_rx_next;

    assign w_hp_done    = (r_hcnt == HW'(HP - 1));
    assign w_edges_done = (r_edge == EW'(2 * DATA_WIDTH));
    // Even edge numbers are leading edges (away from CPOL).
    assign w_leading    = ~r_edge[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts MOSI.
    assign w_sample     = w_leading ^ CPHA;
    // m_axis word still pending after this cycle.
    assign w_m_hold     = r_m_tvalid & ~m_axis_tready;
    assign w_rx_next    = DATA_WIDTH'({r_rx, spi_miso_i});

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state    <= IDLE;
            r_hcnt     <= '0;
            r_edge     <= '0;
            r_wcnt     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sclk     <= CPOL;
            r_cs       <= '1;
            r_mosi     <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_s_tready <= 1'b0;
        end else begin
            if (r_m_tvalid && m_axis_tready)
                r_m_tvalid <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_hcnt <= '0;
                    r_edge <= '0;
                    r_wcnt <= '0;
                    if (s_axis_tvalid && r_s_tready) begin
                        r_s_tready <= 1'b0;
                        // Out-of-range addresses match no select line.
                        for (int i = 0; i < SLAVE_NUM; i++)
                            r_cs[i] <= (AW'(i) != addr_i);
                        // MSB is on the wire as CS falls; CPHA=1 re-drives it
                        // on the first leading edge, so it keeps the full word.
                        r_mosi  <= s_axis_tdata[DATA_WIDTH-1];
                        r_tx    <= CPHA ? s_axis_tdata : (s_axis_tdata << 1);
                        r_state <= TRANSFER;
                    end else begin
                        r_s_tready <= ~w_m_hold;
                    end
                end

                TRANSFER: begin
                    if (w_hp_done) begin
                        r_hcnt <= '0;
                        if (w_edges_done) begin
                            // Trailing half period after the last edge has elapsed.
                            r_cs       <= '1;
                            r_m_tdata  <= r_rx;
                            r_m_tvalid <= 1'b1;
                            r_state    <= (WAIT_TIME == 0) ? IDLE : WAIT;
                        end else begin
                            r_edge <= r_edge + 1'b1;
                            r_sclk <= ~r_sclk;
                            if (w_sample) begin
                                r_rx <= w_rx_next;
                            end else begin
                                r_mosi <= r_tx[DATA_WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (r_wcnt == WW'((WAIT_TIME > 0) ? WAIT_TIME - 1 : 0)) begin
                        r_wcnt  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_clk_o     = r_sclk;
    assign spi_cs_o      = r_cs;
    assign spi_mosi_o    = r_mosi;
    assign s_axis_tready = r_s_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;

`ifdef AXIS_SPI_ASSERT_EN
    if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_chk_mode
        $error("axis_spi_master_core: SPI_MODE %0d out of range", SPI_MODE);
    end
    if (MAIN_CLK < 2 * SPI_CLK) begin : g_chk_clk
        $error("axis_spi_master_core: MAIN_CLK below 2*SPI_CLK");
    end
    if (DATA_WIDTH < 1) begin : g_chk_dw
        $error("axis_spi_master_core: DATA_WIDTH must be at least 1");
    end

    a_m_hold: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (r_m_tvalid && !m_axis_tready) |=> (r_m_tvalid && $stable(r_m_tdata)))
        else $error("axis_spi_master_core: m_axis changed while stalled");
`endif

endmodule

// File: tb/tb_axis_spi_master_core.sv
`timescale 1ns/1ps
module tb_axis_spi_master_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // DUT A: mode 3, three slaves, loopback
    logic [1:0] a_addr;
    logic       a_sclk, a_mosi;
    logic [2:0] a_cs;
    logic [7:0] a_sdata, a_mdata;
    logic       a_svalid, a_sready, a_mvalid, a_mready;

    // DUT B: mode 0, one slave, loopback
    logic [0:0] b_addr;
    logic       b_sclk, b_mosi;
    logic [0:0] b_cs;
    logic [7:0] b_sdata, b_mdata;
    logic       b_svalid, b_sready, b_mvalid, b_mready;

    axis_spi_master_core #(.SPI_MODE(3), .SLAVE_NUM(3)) u_a (
        .clk_i(clk), .arstn_i(rst_n), .addr_i(a_addr),
        .spi_clk_o(a_sclk), .spi_cs_o(a_cs), .spi_mosi_o(a_mosi), .spi_miso_i(a_mosi),
        .s_axis_tdata(a_sdata), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready)
    );

    axis_spi_master_core #(.SPI_MODE(0)) u_b (
        .clk_i(clk), .arstn_i(rst_n), .addr_i(b_addr),
        .spi_clk_o(b_sclk), .spi_cs_o(b_cs), .spi_mosi_o(b_mosi), .spi_miso_i(b_mosi),
        .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_tx[$];
    logic [2:0] exp_cs[$];
    bit hold = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int req);
        total++;
        if (act < req) begin
            bad++;
            $display("FAIL %s: got %0d required at least %0d", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic logic [2:0] cs_of(input logic [1:0] ad);
        logic [2:0] c;
        c = 3'b111;
        if (ad < 2'd3) c[ad] = 1'b0;
        return c;
    endfunction

    // m_axis readiness for A: random 0..10 cycle delay per word, or held off.
    initial begin : drv_mready
        int d;
        d = 0;
        a_mready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold || !a_mvalid) begin
                a_mready = 1'b0;
                d = $urandom_range(0, 10);
            end else if (d == 0) begin
                a_mready = 1'b1;
            end else begin
                d--;
                a_mready = 1'b0;
            end
        end
    end

    // Scoreboard for A's m_axis, plus hold stability while stalled.
    initial begin : mon_a
        logic       stall;
        logic [7:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("a_hold_valid", a_mvalid, 1);
                    check("a_hold_data", a_mdata, held);
                end
                if (a_mvalid && a_mready) begin
                    if (exp_a.size() == 0) fail_now("a_unexpected_word", $sformatf("got %0h, none required", a_mdata));
                    else check("a_rx_word", a_mdata, exp_a.pop_front());
                end
                stall = a_mvalid && !a_mready;
                held  = a_mdata;
            end
        end
    end

    // Scoreboard for B's m_axis.
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (rst_n && b_mvalid && b_mready) begin
                if (exp_b.size() == 0) fail_now("b_unexpected_word", $sformatf("got %0h, none required", b_mdata));
                else check("b_rx_word", b_mdata, exp_b.pop_front());
            end
        end
    end

    // SPI wire monitor for A (mode 3: MOSI captured on rising SCLK).
    initial begin : mon_spi
        logic       prev_sclk, prev_csl, csl;
        logic [7:0] w;
        int         bits, low_run, high_run;
        bit         seen_rise;
        prev_sclk = 1'b1; prev_csl = 1'b0; w = '0;
        bits = 0; low_run = 0; high_run = 0; seen_rise = 1'b0;
        forever begin
            @(negedge clk);
            csl = (a_cs != 3'b111);
            if (!rst_n) begin
                bits = 0; low_run = 0; high_run = 0; seen_rise = 1'b0;
                prev_csl = 1'b0; prev_sclk = a_sclk;
            end else begin
                if (csl && !prev_csl) begin
                    if (seen_rise) check_ge("a_cs_gap", high_run, 52);
                    low_run = 1;
                end else if (!csl && prev_csl) begin
                    check("a_cs_low_cycles", low_run, 34);
                    check("a_sclk_idle_high", a_sclk, 1);
                    seen_rise = 1'b1;
                    high_run = 1;
                end else if (csl) begin
                    low_run++;
                end else begin
                    high_run++;
                end
                if (a_sclk && !prev_sclk) begin
                    w = {w[6:0], a_mosi};
                    bits++;
                    if (bits == 1) begin
                        if (exp_cs.size() == 0) fail_now("a_cs_select", "SCLK activity with no word issued");
                        else check("a_cs_select", a_cs, exp_cs[0]);
                    end
                    if (bits == 8) begin
                        if (exp_tx.size() == 0) fail_now("a_mosi_word", $sformatf("got %0h, none required", w));
                        else check("a_mosi_word", w, exp_tx.pop_front());
                        if (exp_cs.size() != 0) void'(exp_cs.pop_front());
                        bits = 0;
                    end
                end
                prev_sclk = a_sclk;
                prev_csl  = csl;
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input logic [1:0] ad, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        a_sdata = d; a_addr = ad; a_svalid = 1'b1;
        n = 0;
        while (!a_sready && n < 3000) begin @(negedge clk); n++; end
        if (!a_sready) begin
            fail_now("a_send_timeout", "s_axis_tready stayed 0, required 1");
            a_svalid = 1'b0;
        end else begin
            @(posedge clk);
            exp_a.push_back(d); exp_tx.push_back(d); exp_cs.push_back(cs_of(ad));
            #1;
            a_svalid = 1'b0; a_sdata = ~d; a_addr = 2'd0;
        end
    endtask

    task automatic send_b(input logic [7:0] d, input logic mosi_msb);
        int n;
        @(negedge clk);
        b_sdata = d; b_svalid = 1'b1;
        n = 0;
        while (!b_sready && n < 3000) begin @(negedge clk); n++; end
        if (!b_sready) begin
            fail_now("b_send_timeout", "s_axis_tready stayed 0, required 1");
            b_svalid = 1'b0;
        end else begin
            @(posedge clk);
            exp_b.push_back(d);
            #1;
            b_svalid = 1'b0; b_sdata = ~d;
            check("b_cs_at_start", b_cs, 0);
            check("b_mosi_at_cs_fall", b_mosi, mosi_msb);
            check("b_sclk_idle_low", b_sclk, 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 5000) begin @(negedge clk); n++; end
        if (exp_a.size() != 0 || exp_b.size() != 0)
            fail_now("drain_timeout", $sformatf("%0d/%0d words outstanding, required 0", exp_a.size(), exp_b.size()));
    endtask

    logic [7:0] vec_d [10] = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E, 8'h96, 8'h18};
    logic [1:0] vec_a [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
    int         vec_g [10] = '{0, 3, 0, 7, 0, 10, 0, 5, 2, 0};

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hits;
        rst_n = 1'b0;
        a_svalid = 1'b0; a_sdata = '0; a_addr = '0;
        b_svalid = 1'b0; b_sdata = '0; b_addr = '0; b_mready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a_cs", a_cs, 3'b111);
        check("rst_a_sclk", a_sclk, 1);
        check("rst_a_mosi", a_mosi, 0);
        check("rst_a_mvalid", a_mvalid, 0);
        check("rst_a_mdata", a_mdata, 0);
        check("rst_a_sready", a_sready, 0);
        check("rst_b_sclk", b_sclk, 0);
        check("rst_b_cs", b_cs, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_sready", a_sready, 1);

        // Mode 0 loopback
        send_b(8'h3C, 1'b0);
        send_b(8'hC3, 1'b1);
        drain();
        check("b_sclk_final", b_sclk, 0);

        // Mode 3 loopback stream with varied addresses and gaps
        for (int i = 0; i < 10; i++) send_a(vec_d[i], vec_a[i], vec_g[i]);
        drain();

        // Backpressure: received word held, no new word accepted
        hold = 1'b1;
        send_a(8'h69, 2'd0, 0);
        hits = 0;
        while (!a_mvalid && hits < 500) begin @(negedge clk); hits++; end
        check("a_stall_mvalid", a_mvalid, 1);
        @(negedge clk);
        a_sdata = 8'hE1; a_addr = 2'd1; a_svalid = 1'b1;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_sready) hits++;
        end
        check("a_stall_sready_hits", hits, 0);
        check("a_stall_data", a_mdata, 8'h69);
        hold = 1'b0;
        send_a(8'hE1, 2'd1, 0);
        drain();

        // Reset in the middle of bit 4
        send_a(8'hD2, 2'd0, 0);
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cs", a_cs, 3'b111);
        check("rst_mid_sclk", a_sclk, 1);
        check("rst_mid_mvalid", a_mvalid, 0);
        exp_a.delete(); exp_tx.delete(); exp_cs.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        send_a(8'h4B, 2'd0, 0);
        drain();
        repeat (60) @(negedge clk);

        check("a_tx_leftover", exp_tx.size(), 0);
        check("a_final_cs", a_cs, 3'b111);
        check("a_final_sclk", a_sclk, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
